// File: rtl/videoram_pkg.sv
// videoram_pkg
//   Shared constants and types for the VIDEORAM write path.
//   VRAM_ADDR_W / VRAM_DATA_W / VRAM_DEPTH describe the 16 x 8-bit video RAM.
//   vram_wr_state_t is the state type of the write sequencer.
package videoram_pkg;

  localparam int VRAM_ADDR_W = 4;
  localparam int VRAM_DATA_W = 8;
  localparam int VRAM_DEPTH  = 1 << VRAM_ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } vram_wr_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin arbiter: combinational pick plus a registered
//   "last granted" pointer.
//   Ports:
//     CLK, RST_N     clock, asynchronous active-low reset
//     req_a, req_b   request levels
//     enable         allow a grant this cycle
//     update         move the pointer to whichever side is granted
//     gnt            one-hot grant, gnt[0] = A, gnt[1] = B
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       enable,
  input  logic       update,
  output logic [1:0] gnt
);

  // High when B was the most recent winner; resets high so A takes the first tie.
  logic last_b;

  // A tie goes to the side that did not win most recently.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req_a && req_b) begin
        gnt = last_b ? 2'b01 : 2'b10;
      end else if (req_a) begin
        gnt = 2'b01;
      end else if (req_b) begin
        gnt = 2'b10;
      end
    end
  end

  // Every grant, including uncontested ones, moves the pointer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_b <= 1'b1;
    end else if (update && (gnt != 2'b00)) begin
      last_b <= gnt[1];
    end
  end

endmodule

// File: rtl/videoram_write_arbiter.sv
// videoram_write_arbiter
//   Owns the single write port of the VIDEORAM. Two requesters (A: game/board,
//   B: cursor/UI) share it round-robin; a clear sequencer that fills every word
//   with a programmable value takes priority over both.
//   Ports:
//     CLK, RST_N                   clock (= RAM write clock), async active-low reset
//     REQ_x, ADDR_x, DATA_x        level requests with held address/data
//     GNT_x                        one-cycle grant, coincident with the RAM write
//     CLR_START, CLR_DATA          fill start pulse and fill value
//     BUSY, CLR_DONE               fill in progress / one-cycle completion pulse
//     RAM_WADDR, RAM_WDATA, RAM_WEN registered RAM write port
module videoram_write_arbiter
  import videoram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_A,
  input  logic              REQ_B,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] DATA_A,
  input  logic [DATA_W-1:0] DATA_B,
  output logic              GNT_A,
  output logic              GNT_B,
  input  logic              CLR_START,
  input  logic [DATA_W-1:0] CLR_DATA,
  output logic              BUSY,
  output logic              CLR_DONE,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              RAM_WEN
);

  // One extra counter bit lets the end of the fill be seen as 2^ADDR_W
  // instead of relying on a wrap back to zero.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FILL_END = {1'b1, {ADDR_W{1'b0}}};

  vram_wr_state_t    state_q, state_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d, fill_cnt_inc;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;

  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              wen_d, gnt_a_d, gnt_b_d, busy_d, done_d;

  logic              arb_en;
  logic [1:0]        arb_gnt;

  // Requests are served in IDLE unless a fill is starting on the same edge,
  // and also on the edge that leaves DONE so the first grant lands right
  // after the CLR_DONE cycle.
  assign arb_en       = ((state_q == IDLE) && !CLR_START) || (state_q == DONE);
  assign fill_cnt_inc = fill_cnt_q + CNT_W'(1);

  rr_arbiter2 u_arb (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .req_a  (REQ_A),
    .req_b  (REQ_B),
    .enable (arb_en),
    .update (arb_en),
    .gnt    (arb_gnt)
  );

  // All outputs are registered, so the values computed here are what the RAM
  // sees during the next cycle. The fill therefore presents address 0 straight
  // from the CLR_START edge, and the counter always holds the address
  // currently on the port.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    fill_data_d = fill_data_q;
    waddr_d     = RAM_WADDR;
    wdata_d     = RAM_WDATA;
    wen_d       = 1'b0;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (CLR_START) begin
          state_d     = CLEAR;
          fill_data_d = CLR_DATA;
          fill_cnt_d  = '0;
          waddr_d     = '0;
          wdata_d     = CLR_DATA;
          wen_d       = 1'b1;
          busy_d      = 1'b1;
        end
      end
      CLEAR: begin
        if (fill_cnt_inc == FILL_END) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          fill_cnt_d = fill_cnt_inc;
          waddr_d    = fill_cnt_inc[ADDR_W-1:0];
          wdata_d    = fill_data_q;
          wen_d      = 1'b1;
          busy_d     = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The arbiter can only grant when arb_en is high, which excludes any
    // edge on which the fill is driving the port.
    if (arb_gnt[0]) begin
      waddr_d = ADDR_A;
      wdata_d = DATA_A;
      wen_d   = 1'b1;
      gnt_a_d = 1'b1;
    end else if (arb_gnt[1]) begin
      waddr_d = ADDR_B;
      wdata_d = DATA_B;
      wen_d   = 1'b1;
      gnt_b_d = 1'b1;
    end
  end

  // State register; reset abandons any fill in progress.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fill bookkeeping and the registered RAM port / status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fill_cnt_q  <= '0;
      fill_data_q <= '0;
      RAM_WADDR   <= '0;
      RAM_WDATA   <= '0;
      RAM_WEN     <= 1'b0;
      GNT_A       <= 1'b0;
      GNT_B       <= 1'b0;
      BUSY        <= 1'b0;
      CLR_DONE    <= 1'b0;
    end else begin
      fill_cnt_q  <= fill_cnt_d;
      fill_data_q <= fill_data_d;
      RAM_WADDR   <= waddr_d;
      RAM_WDATA   <= wdata_d;
      RAM_WEN     <= wen_d;
      GNT_A       <= gnt_a_d;
      GNT_B       <= gnt_b_d;
      BUSY        <= busy_d;
      CLR_DONE    <= done_d;
    end
  end

endmodule

// File: tb/tb_videoram_write_arbiter.sv
// tb_videoram_write_arbiter
//   Directed bench for videoram_write_arbiter. Inputs change on the falling
//   edge and outputs are sampled on the falling edge, half a cycle after the
//   rising edge that produced them.
module tb_videoram_write_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              REQ_A, REQ_B;
  logic [ADDR_W-1:0] ADDR_A, ADDR_B;
  logic [DATA_W-1:0] DATA_A, DATA_B;
  logic              GNT_A, GNT_B;
  logic              CLR_START;
  logic [DATA_W-1:0] CLR_DATA;
  logic              BUSY, CLR_DONE;
  logic [ADDR_W-1:0] RAM_WADDR;
  logic [DATA_W-1:0] RAM_WDATA;
  logic              RAM_WEN;

  int checks = 0;
  int errors = 0;

  // {BUSY, RAM_WEN, GNT_A, GNT_B, CLR_DONE, RAM_WADDR, RAM_WDATA}
  logic [16:0] obs;
  assign obs = {BUSY, RAM_WEN, GNT_A, GNT_B, CLR_DONE, RAM_WADDR, RAM_WDATA};

  videoram_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .ADDR_A    (ADDR_A),
    .ADDR_B    (ADDR_B),
    .DATA_A    (DATA_A),
    .DATA_B    (DATA_B),
    .GNT_A     (GNT_A),
    .GNT_B     (GNT_B),
    .CLR_START (CLR_START),
    .CLR_DATA  (CLR_DATA),
    .BUSY      (BUSY),
    .CLR_DONE  (CLR_DONE),
    .RAM_WADDR (RAM_WADDR),
    .RAM_WDATA (RAM_WDATA),
    .RAM_WEN   (RAM_WEN)
  );

  always #5 CLK = ~CLK;

  // A pending, not-yet-granted request must keep its address and data.
  logic              last_req_a = 1'b0, last_req_b = 1'b0;
  logic [ADDR_W-1:0] last_addr_a, last_addr_b;
  logic [DATA_W-1:0] last_data_a, last_data_b;

  always @(posedge CLK) begin
    if (RST_N) begin
      if (last_req_a && !GNT_A && REQ_A && (ADDR_A !== last_addr_a || DATA_A !== last_data_a)) begin
        errors++;
        $display("[TB] FAIL protocol_a addr/data %h/%h changed while pending, held %h/%h",
                 ADDR_A, DATA_A, last_addr_a, last_data_a);
      end
      if (last_req_b && !GNT_B && REQ_B && (ADDR_B !== last_addr_b || DATA_B !== last_data_b)) begin
        errors++;
        $display("[TB] FAIL protocol_b addr/data %h/%h changed while pending, held %h/%h",
                 ADDR_B, DATA_B, last_addr_b, last_data_b);
      end
    end
    last_req_a  <= REQ_A;
    last_addr_a <= ADDR_A;
    last_data_a <= DATA_A;
    last_req_b  <= REQ_B;
    last_addr_b <= ADDR_B;
    last_data_b <= DATA_B;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic apply_idle_inputs();
    REQ_A     = 1'b0;
    REQ_B     = 1'b0;
    ADDR_A    = '0;
    ADDR_B    = '0;
    DATA_A    = '0;
    DATA_B    = '0;
    CLR_START = 1'b0;
    CLR_DATA  = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    apply_idle_inputs();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    apply_idle_inputs();
    RST_N = 1'b1;
    #2;
    RST_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h expected %h", obs, 17'd0);
    end
    RST_N = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      checks++;
      if (obs !== 17'd0) begin
        errors++;
        $display("[TB] FAIL reset_quiet cycle %0d got %h expected %h", c, obs, 17'd0);
      end
    end
  endtask

  task automatic test_single();
    @(negedge CLK);
    REQ_A  = 1'b1;
    ADDR_A = 4'd3;
    DATA_A = 8'h2A;
    @(negedge CLK);
    checks++;
    if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 8'h2A}) begin
      errors++;
      $display("[TB] FAIL single_grant got %h expected %h", obs, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 8'h2A});
    end
    REQ_A = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 8'h2A}) begin
      errors++;
      $display("[TB] FAIL single_hold got %h expected %h", obs, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 8'h2A});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] bb_addr [4] = '{4'd1, 4'd6, 4'd10, 4'd15};
    logic [7:0] bb_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge CLK);
    REQ_A  = 1'b1;
    ADDR_A = bb_addr[0];
    DATA_A = bb_data[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, bb_addr[i], bb_data[i]}) begin
        errors++;
        $display("[TB] FAIL back_to_back %0d got %h expected %h", i, obs,
                 {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, bb_addr[i], bb_data[i]});
      end
      if (i < 3) begin
        ADDR_A = bb_addr[i+1];
        DATA_A = bb_data[i+1];
      end else begin
        REQ_A = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    logic [16:0] exp_v;
    do_reset();
    REQ_A  = 1'b1;
    ADDR_A = 4'd5;
    DATA_A = 8'hA5;
    REQ_B  = 1'b1;
    ADDR_B = 4'd9;
    DATA_B = 8'hB9;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      exp_v = (i % 2 == 0) ? {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 8'hA5}
                           : {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 8'hB9};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL contention %0d got %h expected %h", i, obs, exp_v);
      end
    end
    REQ_A = 1'b0;
    REQ_B = 1'b0;
  endtask

  task automatic test_fill();
    logic [3:0]  a;
    logic [16:0] exp_v;
    do_reset();
    CLR_START = 1'b1;
    CLR_DATA  = 8'h00;
    REQ_B     = 1'b1;
    ADDR_B    = 4'hC;
    DATA_B    = 8'h77;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      a = 4'(i);
      exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, 8'h00};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL fill_write %0d got %h expected %h", i, obs, exp_v);
      end
      CLR_START = 1'b0;
      CLR_DATA  = 8'hFF;
    end
    @(negedge CLK);
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 8'h00}) begin
      errors++;
      $display("[TB] FAIL fill_done got %h expected %h", obs, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 8'h00});
    end
    @(negedge CLK);
    checks++;
    if (obs !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hC, 8'h77}) begin
      errors++;
      $display("[TB] FAIL fill_then_gnt_b got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hC, 8'h77});
    end
    REQ_B = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 8'h77}) begin
      errors++;
      $display("[TB] FAIL fill_after_idle got %h expected %h", obs, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 8'h77});
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [3:0]  a;
    logic [16:0] exp_v;
    @(negedge CLK);
    CLR_START = 1'b1;
    CLR_DATA  = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      CLR_START = 1'b0;
      a = 4'(i);
      exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, 8'h5A};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL midfill_write %0d got %h expected %h", i, obs, exp_v);
      end
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("[TB] FAIL midfill_reset got %h expected %h", obs, 17'd0);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      checks++;
      if ({CLR_DONE, BUSY, RAM_WEN} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL midfill_no_done cycle %0d got %b expected %b", c, {CLR_DONE, BUSY, RAM_WEN}, 3'b000);
      end
    end
    CLR_START = 1'b1;
    CLR_DATA  = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      CLR_START = 1'b0;
      a = 4'(i);
      exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, 8'hC3};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL refill_write %0d got %h expected %h", i, obs, exp_v);
      end
    end
    @(negedge CLK);
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 8'hC3}) begin
      errors++;
      $display("[TB] FAIL refill_done got %h expected %h", obs, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 8'hC3});
    end
  endtask

  task automatic test_ignored_start();
    logic [3:0]  a;
    logic [16:0] exp_v;
    int          writes = 0;
    int          dones  = 0;
    @(negedge CLK);
    CLR_START = 1'b1;
    CLR_DATA  = 8'h3C;
    for (int c = 1; c <= 22; c++) begin
      @(negedge CLK);
      a = 4'(c - 1);
      if (c <= 16)       exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, 8'h3C};
      else if (c == 17)  exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 8'h3C};
      else               exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 8'h3C};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL ignored_start cycle %0d got %h expected %h", c, obs, exp_v);
      end
      if (RAM_WEN === 1'b1)  writes++;
      if (CLR_DONE === 1'b1) dones++;
      // Retrigger attempts: one mid-fill, one in the DONE cycle.
      CLR_START = (c == 5 || c == 17);
      CLR_DATA  = (c == 5 || c == 17) ? 8'hFF : 8'h3C;
    end
    checks++;
    if (writes != 16) begin
      errors++;
      $display("[TB] FAIL ignored_start_writes got %0d expected %0d", writes, 16);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("[TB] FAIL ignored_start_dones got %0d expected %0d", dones, 1);
    end
  endtask

  initial begin
    $display("[TB] starting videoram_write_arbiter bench");
    test_reset();
    test_single();
    test_back_to_back();
    test_contention();
    test_fill();
    test_reset_mid_fill();
    test_ignored_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
